// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked ALU pipeline (alu_pipe_hs) and its
// iterative divider (alu_div_iter).
//   - OP_* : 5-bit opcodes, identical to the CPU's ALU opcode encoding.
//   - div_state_t : divider-control FSM states (IDLE, RUN, DONE).
//   - FLAG_* : bit positions inside out_flags when ALU_PIPE_HS_FLAGS_EN is
//     defined (zero / negative / divide-by-zero).
// No ports; import with "import alu_pkg::*;".
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int FLAGS_W   = 3;
    localparam int FLAG_ZERO = 0;
    localparam int FLAG_NEG  = 1;
    localparam int FLAG_DBZ  = 2;

endpackage

// File: rtl/alu_div_iter.sv
// ----------------------------------------------------------------------------
// alu_div_iter
// Signed iterative restoring divider, one quotient bit per clock.
// Operands are converted to magnitudes on start; signs are re-applied on the
// final step so quot/rem are valid in the same cycle done rises.
//   quotient truncates toward zero, remainder takes the dividend's sign.
//   b == 0 : quot = all ones, rem = a (no early exit).
//   most-negative / -1 : quot = most-negative, rem = 0.
// Ports:
//   clk, clear_n  clock, asynchronous active-low reset
//   start         load a/b and begin (takes priority over iteration)
//   a, b          signed dividend / divisor, DATA_W bits
//   done          high from the final step until the next start
//   quot, rem     signed results, valid while done is high
// ----------------------------------------------------------------------------
module alu_div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] quot,
    output logic [DATA_W-1:0] rem
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0]     LAST = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);

    function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] x);
        return ~x + ONE;
    endfunction

    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;   // dividend magnitude shifting out, quotient shifting in
    logic [DATA_W-1:0] dvs_r;
    logic [CW-1:0]     cnt_r;
    logic              run_r;
    logic              done_r;
    logic              q_neg_r;
    logic              r_neg_r;

    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] diff;
    logic              ge;
    logic [DATA_W-1:0] r_next;
    logic [DATA_W-1:0] q_next;

    // One restoring step. The partial remainder is always below the divisor,
    // so a W-bit difference is exact whenever the subtraction is taken.
    always_comb begin
        trial  = {rem_r, quo_r[DATA_W-1]};
        ge     = (trial >= {1'b0, dvs_r});
        diff   = trial[DATA_W-1:0] - dvs_r;
        r_next = ge ? diff : trial[DATA_W-1:0];
        q_next = {quo_r[DATA_W-2:0], ge};
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rem_r   <= '0;
            quo_r   <= '0;
            dvs_r   <= '0;
            cnt_r   <= '0;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (start) begin
            rem_r   <= '0;
            quo_r   <= a[DATA_W-1] ? negate(a) : a;
            dvs_r   <= b[DATA_W-1] ? negate(b) : b;
            // Division by zero keeps the raw all-ones quotient.
            q_neg_r <= (a[DATA_W-1] ^ b[DATA_W-1]) && (b != '0);
            r_neg_r <= a[DATA_W-1];
            cnt_r   <= '0;
            run_r   <= 1'b1;
            done_r  <= 1'b0;
        end else if (run_r) begin
            if (cnt_r == LAST) begin
                quo_r  <= q_neg_r ? negate(q_next) : q_next;
                rem_r  <= r_neg_r ? negate(r_next) : r_next;
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                quo_r <= q_next;
                rem_r <= r_next;
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign done = done_r;
    assign quot = quo_r;
    assign rem  = rem_r;

endmodule

// File: rtl/alu_pipe_hs.sv
// ----------------------------------------------------------------------------
// alu_pipe_hs
// Parametrised ALU with valid/ready handshakes on input and output. One
// operand stage (S1) feeds an output register (OUT). All ops except DIV
// complete in S1 in one cycle; DIV runs on alu_div_iter for DATA_W cycles.
//
// Handshake: a transfer happens on any rising edge where valid && ready on
// that interface. in_ready never depends on in_valid; out_result/out_valid
// (and out_flags) hold steady while out_valid && !out_ready.
//
// Optional build macro: ALU_PIPE_HS_FLAGS_EN adds the out_flags port
// (bit0 zero, bit1 negative, bit2 divide-by-zero) registered with out_result.
//
// Ports:
//   clk, clear_n    clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_a, in_b operands, in_op opcode
//   out_valid/ready output handshake; out_result = {HI, LO}
//   busy            divider iterating (FSM in RUN)
//   out_flags       result flags (only with ALU_PIPE_HS_FLAGS_EN)
//   dbg_state       divider FSM state (div_state_t encoding)
// ----------------------------------------------------------------------------
module alu_pipe_hs
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = $clog2(DATA_W)
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_a,
    input  logic [DATA_W-1:0]   in_b,
    input  logic [4:0]          in_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_result,
    output logic                busy,
`ifdef ALU_PIPE_HS_FLAGS_EN
    output logic [FLAGS_W-1:0]  out_flags,
`endif
    output logic [1:0]          dbg_state
);

    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

    // ---------------- S1 operand stage ----------------
    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic [4:0]        s1_op;

    div_state_t        state;
    logic [CW-1:0]     cnt;

    logic              div_done;
    logic [DATA_W-1:0] div_quot;
    logic [DATA_W-1:0] div_rem;

    logic s1_complete;
    logic out_free;
    logic out_load;
    logic in_fire;
    logic div_start;

    assign s1_complete = s1_valid &&
                         ((s1_op != OP_DIV) || ((state == ST_DONE) && div_done));
    assign out_free    = !out_valid || out_ready;
    assign out_load    = s1_complete && out_free;
    // Gated by clear_n so the block advertises nothing while held in reset.
    assign in_ready    = clear_n && (!s1_valid || out_load);
    assign in_fire     = in_valid && in_ready;
    // The divider is loaded straight from the input on the accept edge, so it
    // iterates while S1 holds the DIV and finishes DATA_W edges later.
    assign div_start   = in_fire && (in_op == OP_DIV);

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_op    <= in_op;
        end else if (out_load) begin
            s1_valid <= 1'b0;
        end
    end

    // ---------------- divider control FSM ----------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (div_start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    // A new DIV can only be accepted on the edge this one
                    // leaves S1, so restart directly in that case.
                    if (div_start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end else if (out_load) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_RUN);
    assign dbg_state = state;

    alu_div_iter #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk     (clk),
        .clear_n (clear_n),
        .start   (div_start),
        .a       (in_a),
        .b       (in_b),
        .done    (div_done),
        .quot    (div_quot),
        .rem     (div_rem)
    );

    // ---------------- S1 result ----------------
    logic [SH_W-1:0]     sh;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] rot;
    logic [DATA_W-1:0]   lo;
    logic [DATA_W-1:0]   hi;

    assign sh = s1_b[SH_W-1:0];
    // Sign-extended operands make the truncated 2W-bit product the signed one.
    assign prod = {{DATA_W{s1_a[DATA_W-1]}}, s1_a} * {{DATA_W{s1_b[DATA_W-1]}}, s1_b};

    always_comb begin
        lo  = '0;
        hi  = '0;
        rot = '0;
        case (s1_op)
            OP_ADD:  lo = s1_a + s1_b;
            OP_SUB:  lo = s1_a - s1_b;
            OP_AND:  lo = s1_a & s1_b;
            OP_OR:   lo = s1_a | s1_b;
            OP_NEG:  lo = ~s1_b + ONE;
            OP_NOT:  lo = ~s1_b;
            OP_SHR:  lo = s1_a >> sh;
            OP_SHRA: lo = $unsigned($signed(s1_a) >>> sh);
            OP_SHL:  lo = s1_a << sh;
            OP_ROR: begin
                rot = {s1_a, s1_a} >> sh;
                lo  = rot[DATA_W-1:0];
            end
            OP_ROL: begin
                rot = {s1_a, s1_a} << sh;
                lo  = rot[2*DATA_W-1:DATA_W];
            end
            OP_MUL: {hi, lo} = prod;
            OP_DIV: begin
                hi = div_rem;
                lo = div_quot;
            end
            default: ;
        endcase
    end

`ifdef ALU_PIPE_HS_FLAGS_EN
    logic [FLAGS_W-1:0] flags_next;
    logic               wide_op;

    assign wide_op = (s1_op == OP_MUL) || (s1_op == OP_DIV);

    always_comb begin
        flags_next            = '0;
        flags_next[FLAG_ZERO] = ({hi, lo} == '0);
        flags_next[FLAG_NEG]  = wide_op ? hi[DATA_W-1] : lo[DATA_W-1];
        flags_next[FLAG_DBZ]  = (s1_op == OP_DIV) && (s1_b == '0);
    end
`endif

    // ---------------- OUT register ----------------
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            out_valid  <= 1'b0;
            out_result <= '0;
`ifdef ALU_PIPE_HS_FLAGS_EN
            out_flags  <= '0;
`endif
        end else if (out_load) begin
            out_valid  <= 1'b1;
            out_result <= {hi, lo};
`ifdef ALU_PIPE_HS_FLAGS_EN
            out_flags  <= flags_next;
`endif
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
